// File: rtl/eth_wbmem_pkg.sv
// Shared types and constants for the Ethernet DMA Wishbone memory responder.
package eth_wbmem_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} wbmem_state_t;

  // One Wishbone request as presented by the MAC master port
  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic [WB_DW-1:0] dat;
    logic [2:0]       cti;
    logic [1:0]       bte;
  } wb_req_t;

  // Replace the selected byte lanes of a stored word with new data
  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old_word,
                                                  input logic [WB_DW-1:0] wdat,
                                                  input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] res;
    res = old_word;
    for (int n = 0; n < int'(WB_SW); n++) begin
      if (sel[n]) res[8*n +: 8] = wdat[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_wbmem_ram.sv
// Single-port byte-enabled word RAM: synchronous write, asynchronous read at the same index.
module eth_wbmem_ram
  import eth_wbmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic             SysClk,
  input  logic             we,
  input  logic [WB_SW-1:0] sel,
  input  logic [AW-1:0]    idx,
  input  logic [WB_DW-1:0] wdat,
  output logic [WB_DW-1:0] rdat
);

  logic [WB_DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge SysClk) begin
    if (we) mem[idx] <= byte_merge(mem[idx], wdat, sel);
  end

  assign rdat = mem[idx];

endmodule

// File: rtl/eth_wb_mem_responder.sv
// Wishbone B3 slave memory serving the Ethernet MAC DMA port, with wait states and linear bursts.
// Define ETH_WBMEM_RANGE_ERR_EN to terminate out-of-range first beats with err instead of wrapping.
module eth_wb_mem_responder
  import eth_wbmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        SysClk,
  input  logic        rst,
  input  logic [31:0] m_wb_adr_o,
  input  logic [3:0]  m_wb_sel_o,
  input  logic        m_wb_we_o,
  input  logic [31:0] m_wb_dat_o,
  input  logic        m_wb_cyc_o,
  input  logic        m_wb_stb_o,
  input  logic [2:0]  m_wb_cti_o,
  input  logic [1:0]  m_wb_bte_o,
  output logic [31:0] m_wb_dat_i,
  output logic        m_wb_ack_i,
  output logic        m_wb_err_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WaitLoad = CW'(WAIT_CYCLES - 1);

`ifdef ETH_WBMEM_RANGE_ERR_EN
  localparam bit RangeErrEn = 1'b1;
`else
  localparam bit RangeErrEn = 1'b0;
`endif

  wb_req_t       req;
  wbmem_state_t  state;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] beat;
  logic          first_bad;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   dat_q;

  logic          req_c;
  logic          burst_c;
  logic          in_range_c;
  logic          bad_c;
  logic          ram_we_c;
  logic [31:0]   word_off_c;
  logic [AW-1:0] req_idx_c;
  logic [AW-1:0] ram_idx_c;
  logic [31:0]   ram_rdat_c;

  assign req = '{adr: m_wb_adr_o, sel: m_wb_sel_o, we: m_wb_we_o, dat: m_wb_dat_o,
                 cti: m_wb_cti_o, bte: m_wb_bte_o};

  // Address decode, burst continuation and RAM port steering
  always_comb begin
    word_off_c = (req.adr - BASE_ADDR) >> 2;
    req_idx_c  = AW'(word_off_c);
    in_range_c = word_off_c < DEPTH_WORDS;
    bad_c      = RangeErrEn && !in_range_c;
    req_c      = m_wb_cyc_o && m_wb_stb_o;
    burst_c    = req_c && (req.cti == CTI_INCR) && (req.bte == BTE_LINEAR);
    ram_we_c   = (state == ACK) && !err_q && req.we && req_c && !rst;
    ram_idx_c  = beat;
    case (state)
      IDLE:    ram_idx_c = req_idx_c;
      WAIT:    ram_idx_c = beat;
      default: ram_idx_c = req.we ? beat : AW'(beat + AW'(1));
    endcase
  end

  eth_wbmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .SysClk(SysClk),
    .we    (ram_we_c),
    .sel   (req.sel),
    .idx   (ram_idx_c),
    .wdat  (req.dat),
    .rdat  (ram_rdat_c)
  );

  // Cycle FSM; terminations and read data are registered and default low each cycle
  always_ff @(posedge SysClk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      beat      <= '0;
      first_bad <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      case (state)
        IDLE: begin
          if (req_c) begin
            beat      <= req_idx_c;
            first_bad <= bad_c;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
              ack_q <= !bad_c;
              err_q <= bad_c;
              dat_q <= (bad_c || req.we) ? '0 : ram_rdat_c;
            end else begin
              state    <= WAIT;
              wait_cnt <= WaitLoad;
            end
          end
        end
        WAIT: begin
          if (!req_c) begin
            state <= IDLE;
          end else if (wait_cnt == '0) begin
            state <= ACK;
            ack_q <= !first_bad;
            err_q <= first_bad;
            dat_q <= (first_bad || req.we) ? '0 : ram_rdat_c;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: begin
          if (!err_q && burst_c) begin
            beat  <= AW'(beat + AW'(1));
            ack_q <= 1'b1;
            dat_q <= req.we ? '0 : ram_rdat_c;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign m_wb_ack_i = ack_q;
  assign m_wb_err_i = err_q;
  assign m_wb_dat_i = dat_q;

endmodule

// File: tb/tb_eth_wb_mem_responder.sv
// Bench for eth_wb_mem_responder: two instances (0 and 3 wait states) against a word-array memory model.
module tb_eth_wb_mem_responder;
  import eth_wbmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  logic        rst;
  logic [31:0] adr, wdo;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cur;
  logic [31:0] dat0, dat3, dat_s;
  logic        ack0, ack3, err0, err3, ack_s, err_s;

  assign ack_s = cur ? ack3 : ack0;
  assign err_s = cur ? err3 : err0;
  assign dat_s = cur ? dat3 : dat0;

  eth_wb_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .SysClk(SysClk), .rst(rst), .m_wb_adr_o(adr), .m_wb_sel_o(sel), .m_wb_we_o(we),
    .m_wb_dat_o(wdo), .m_wb_cyc_o(cyc & ~cur), .m_wb_stb_o(stb), .m_wb_cti_o(cti),
    .m_wb_bte_o(bte), .m_wb_dat_i(dat0), .m_wb_ack_i(ack0), .m_wb_err_i(err0));

  eth_wb_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .SysClk(SysClk), .rst(rst), .m_wb_adr_o(adr), .m_wb_sel_o(sel), .m_wb_we_o(we),
    .m_wb_dat_o(wdo), .m_wb_cyc_o(cyc & cur), .m_wb_stb_o(stb), .m_wb_cti_o(cti),
    .m_wb_bte_o(bte), .m_wb_dat_i(dat3), .m_wb_ack_i(ack3), .m_wb_err_i(err3));

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [2][DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o / 32'd4) >= DEPTH;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o / 32'd4) % DEPTH);
  endfunction

  task automatic mwrite(input int d, input int i, input logic [3:0] s, input logic [31:0] v);
    for (int n = 0; n < 4; n++)
      if (s[n]) mdl[d][i][8*n +: 8] = v[8*n +: 8];
  endtask

  task automatic wb_single(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] c,
                           output logic [31:0] rdat, output logic t_ack, output logic t_err,
                           output int lat, output logic after_term, output logic [31:0] after_dat);
    @(posedge SysClk); #1;
    adr = a; we = w; sel = s; wdo = d; cti = c; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge SysClk); #1; lat++;
    end while (!(ack_s || err_s) && lat < 40);
    t_ack = ack_s; t_err = err_s; rdat = dat_s;
    @(posedge SysClk); #1;
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
    after_term = ack_s | err_s; after_dat = dat_s;
  endtask

  task automatic wb_burst(input logic [31:0] a, input logic w, input int n,
                          input logic [31:0] wd [16], input int rst_at,
                          output logic [31:0] rd [16], output int nacks, output int lat,
                          output logic after_term);
    @(posedge SysClk); #1;
    adr = a; we = w; sel = 4'hF; wdo = wd[0]; cti = (n == 1) ? CTI_EOB : CTI_INCR;
    bte = BTE_LINEAR; cyc = 1'b1; stb = 1'b1;
    nacks = 0; lat = 0;
    for (int i = 0; i < 16; i++) rd[i] = '0;
    do begin
      @(posedge SysClk); #1; lat++;
    end while (!ack_s && lat < 40);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge SysClk); #1;
        wdo = wd[i]; cti = (i == n - 1) ? CTI_EOB : CTI_INCR;
      end
      if (!ack_s) break;
      rd[i] = dat_s; nacks++;
      if (i == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    @(posedge SysClk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
    after_term = ack_s | err_s;
  endtask

  task automatic wb_abort(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic seen);
    @(posedge SysClk); #1;
    adr = a; we = w; sel = 4'hF; wdo = d; cti = CTI_CLASSIC; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge SysClk); #1; seen |= ack_s | err_s;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (8) begin
      @(posedge SysClk); #1; seen |= ack_s | err_s;
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [2:0]  cti;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rdat, adat, v;
    logic        t_ack, t_err, aft, seen;
    int          lat, nacks, idx, n, wt;
    logic [31:0] wd [16];
    logic [31:0] rd [16];

    rst = 1'b1; cur = 1'b0; adr = '0; wdo = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = 2'b00;
    repeat (3) @(posedge SysClk);
    #1;
    chk("rst_ack0", ack0, 1'b0); chk("rst_err0", err0, 1'b0); chk("rst_dat0", dat0, 32'h0);
    chk("rst_ack3", ack3, 1'b0); chk("rst_err3", err3, 1'b0); chk("rst_dat3", dat3, 32'h0);
    rst = 1'b0;

    // Known contents everywhere so any read has a defined expectation
    for (int d = 0; d < 2; d++) begin
      cur = d[0];
      for (int i = 0; i < int'(DEPTH); i++) begin
        v = $urandom;
        wb_single(BASE + 32'(i * 4), 1'b1, 4'hF, v, CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
        mwrite(d, i, 4'hF, v);
      end
    end

    tbl.push_back('{"w10",    1'b1, 32'h10,   4'hF,    32'hDEADBEEF, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"r10",    1'b0, 32'h10,   4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{"r13",    1'b0, 32'h13,   4'h0,    32'h0,        CTI_CLASSIC, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{"w20ff",  1'b1, 32'h20,   4'hF,    32'hFFFFFFFF, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"w20sel", 1'b1, 32'h20,   4'b0101, 32'h11223344, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"r20a",   1'b0, 32'h20,   4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'hFF22FF44});
    tbl.push_back('{"w20b3",  1'b1, 32'h20,   4'b1000, 32'h77000000, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"r20b",   1'b0, 32'h20,   4'h1,    32'h0,        CTI_CLASSIC, 1'b0, 32'h7722FF44});
    tbl.push_back('{"w0",     1'b1, 32'h0,    4'hF,    32'hCAFEF00D, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"w4",     1'b1, 32'h4,    4'hF,    32'h55AA55AA, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"wlast",  1'b1, 32'hFFC,  4'hF,    32'h0BADC0DE, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"rlast",  1'b0, 32'hFFC,  4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'h0BADC0DE});
`ifdef ETH_WBMEM_RANGE_ERR_EN
    tbl.push_back('{"roob",   1'b0, 32'h1000, 4'hF,    32'h0,        CTI_CLASSIC, 1'b1, 32'h0});
    tbl.push_back('{"roobb",  1'b0, 32'h1000, 4'hF,    32'h0,        CTI_INCR,    1'b1, 32'h0});
    tbl.push_back('{"woob",   1'b1, 32'h1004, 4'hF,    32'h12345678, CTI_CLASSIC, 1'b1, 32'h0});
    tbl.push_back('{"r4",     1'b0, 32'h4,    4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'h55AA55AA});
`else
    tbl.push_back('{"roob",   1'b0, 32'h1000, 4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'hCAFEF00D});
    tbl.push_back('{"rneg",   1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,       CTI_CLASSIC, 1'b0, 32'h0BADC0DE});
    tbl.push_back('{"woob",   1'b1, 32'h1004, 4'hF,    32'h12345678, CTI_CLASSIC, 1'b0, 32'h0});
    tbl.push_back('{"r4",     1'b0, 32'h4,    4'hF,    32'h0,        CTI_CLASSIC, 1'b0, 32'h12345678});
`endif

    cur = 1'b0;
    foreach (tbl[k]) begin
      wb_single(tbl[k].adr, tbl[k].we, tbl[k].sel, tbl[k].wdat, tbl[k].cti,
                rdat, t_ack, t_err, lat, aft, adat);
      chk({tbl[k].name, "_ack"}, t_ack, !tbl[k].exp_err);
      chk({tbl[k].name, "_err"}, t_err, tbl[k].exp_err);
      chk({tbl[k].name, "_lat"}, lat, 1);
      chk({tbl[k].name, "_1cyc"}, aft, 1'b0);
      chk({tbl[k].name, "_datlow"}, adat, 32'h0);
      if (!tbl[k].we) chk({tbl[k].name, "_dat"}, rdat, tbl[k].exp_dat);
      if (tbl[k].we && !tbl[k].exp_err) mwrite(0, widx(tbl[k].adr), tbl[k].sel, tbl[k].wdat);
    end

    // Four-beat incrementing read from preloaded words 0x40..0x43
    for (int i = 0; i < 4; i++) begin
      wb_single(32'h100 + 32'(i * 4), 1'b1, 4'hF, 32'(i + 1), CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
      mwrite(0, 16'h40 + i, 4'hF, 32'(i + 1));
    end
    for (int i = 0; i < 16; i++) wd[i] = '0;
    wb_burst(32'h100, 1'b0, 4, wd, -1, rd, nacks, lat, aft);
    chk("burst4_nacks", nacks, 4);
    chk("burst4_lat", lat, 1);
    chk("burst4_end", aft, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("burst4_d%0d", i), rd[i], 32'(i + 1));

    // Reset asserted during the second beat of a write burst
    for (int i = 0; i < 4; i++) wd[i] = 32'hA000_0000 + 32'(i);
    wb_burst(32'h200, 1'b1, 4, wd, 1, rd, nacks, lat, aft);
    mwrite(0, 16'h80, 4'hF, wd[0]);
    chk("rstb_nacks", nacks, 2);
    chk("rstb_ackoff", aft, 1'b0);
    wb_single(32'h204, 1'b0, 4'hF, 32'h0, CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
    chk("rstb_beat2", rdat, mdl[0][16'h81]);
    chk("rstb_new_ack", t_ack, 1'b1);
    chk("rstb_new_lat", lat, 1);
    wb_single(32'h200, 1'b0, 4'hF, 32'h0, CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
    chk("rstb_beat1", rdat, 32'hA000_0000);

    // Three wait states: latency and aborted cycles
    cur = 1'b1;
    wb_single(32'h10, 1'b0, 4'hF, 32'h0, CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
    chk("w3_lat", lat, 4);
    chk("w3_dat", rdat, mdl[1][4]);
    chk("w3_1cyc", aft, 1'b0);
    wb_abort(32'h10, 1'b0, 32'h0, seen);
    chk("w3_abort_rd", seen, 1'b0);
    wb_abort(32'h10, 1'b1, ~mdl[1][4], seen);
    chk("w3_abort_wr", seen, 1'b0);
    wb_single(32'h10, 1'b0, 4'hF, 32'h0, CTI_CLASSIC, rdat, t_ack, t_err, lat, aft, adat);
    chk("w3_unchanged", rdat, mdl[1][4]);

    // Random classic and burst traffic on both instances
    for (int it = 0; it < 300; it++) begin
      cur = ($urandom % 4) == 0;
      wt  = cur ? 3 : 0;
      idx = int'($urandom % DEPTH);
      case ($urandom % 4)
        0, 1: begin
          v = $urandom;
          we = $urandom % 2;
          sel = 4'($urandom);
          wb_single(BASE + 32'(idx * 4) + 32'($urandom % 4), we, sel, v, CTI_CLASSIC,
                    rdat, t_ack, t_err, lat, aft, adat);
          chk($sformatf("rnd%0d_ack", it), t_ack, 1'b1);
          chk($sformatf("rnd%0d_lat", it), lat, wt + 1);
          chk($sformatf("rnd%0d_1cyc", it), aft, 1'b0);
          if (we) mwrite(int'(cur), idx, sel, v);
          else chk($sformatf("rnd%0d_dat", it), rdat, mdl[int'(cur)][idx]);
        end
        default: begin
          n = 1 + int'($urandom % 6);
          if ($urandom % 4 == 0) idx = int'(DEPTH) - 1 - int'($urandom % 3);
          for (int i = 0; i < 16; i++) wd[i] = $urandom;
          v = $urandom % 2;
          wb_burst(BASE + 32'(idx * 4), v[0], n, wd, -1, rd, nacks, lat, aft);
          chk($sformatf("rb%0d_nacks", it), nacks, n);
          chk($sformatf("rb%0d_lat", it), lat, wt + 1);
          chk($sformatf("rb%0d_end", it), aft, 1'b0);
          for (int i = 0; i < n; i++) begin
            if (v[0]) mwrite(int'(cur), (idx + i) % int'(DEPTH), 4'hF, wd[i]);
            else chk($sformatf("rb%0d_d%0d", it, i), rd[i], mdl[int'(cur)][(idx + i) % int'(DEPTH)]);
          end
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_wb_mem_responder.md
# eth_wb_mem_responder

Wishbone B3 slave memory that answers the Ethernet MAC's DMA master port (`m_wb_*`). The MAC uses this port to fetch TX buffers and store RX buffers. The block holds a word-addressed, byte-enabled RAM and returns ack or err with a configurable number of wait states. It supports classic cycles and linear incrementing bursts. It sits in the environment beside the MAC pin interface and models system memory for bench and emulation runs.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be aligned to `DEPTH_WORDS*4`.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words. Power of two, 16..65536.
- `WAIT_CYCLES`, 0: wait states inserted before the first ack of each cycle. Range 0..15.

- `SysClk` input 1: single clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m_wb_adr_o` input 32: byte address from the MAC. Bits [1:0] are ignored.
- `m_wb_sel_o` input 4: byte lane enables. Bit n enables byte n.
- `m_wb_we_o` input 1: write (1) or read (0).
- `m_wb_dat_o` input 32: write data from the MAC.
- `m_wb_cyc_o` input 1: bus cycle valid.
- `m_wb_stb_o` input 1: strobe.
- `m_wb_cti_o` input 3: cycle type. 000 classic, 010 incrementing burst, 111 end of burst.
- `m_wb_bte_o` input 2: burst type extension. Only 00 (linear) is honoured.
- `m_wb_dat_i` output 32: read data to the MAC.
- `m_wb_ack_i` output 1: normal termination.
- `m_wb_err_i` output 1: error termination.

## Operation
- Request: `m_wb_cyc_o & m_wb_stb_o` sampled high at a rising edge.
- Word index = (`adr` − `BASE_ADDR`) >> 2. It is in range when the result is less than `DEPTH_WORDS`.
- FSM states:
  - IDLE
    - On a request with `WAIT_CYCLES`=0, go to ACK.
    - On a request otherwise, go to WAIT. Load the wait counter with `WAIT_CYCLES`−1 and latch the word index into the beat counter.
  - WAIT
    - Decrement the counter. At 0, go to ACK.
    - If `cyc` or `stb` drops, go to IDLE with no termination and no write.
  - ACK
    - `ack` (or `err`) is high for this cycle.
    - Write: for each lane with `sel`[n]=1, write byte n of `m_wb_dat_o` to the RAM at the beat index on this edge.
    - Read: `m_wb_dat_i` presents the RAM word at the beat index. Unselected lanes still carry RAM data.
    - Next state:
      - `cti`=010 and `bte`=00 and `stb` still high: stay in ACK and increment the beat index by 1. The index wraps modulo `DEPTH_WORDS`. No wait states are added within a burst.
      - Any other `cti` (000, 111, reserved) or `bte`≠00: return to IDLE. Classic ack is one cycle wide.
      - `cyc` low: go to IDLE immediately.
- Bursts: the beat index comes from the internal counter, not the per-beat `adr`. The MAC's address is only checked at the first beat.
- Terminations: `ack` and `err` are never high together. Neither is high outside the ACK state.

## Timing
- Reset: `m_wb_ack_i`=0, `m_wb_err_i`=0, `m_wb_dat_i`=32'h0, FSM in IDLE, beat/wait counters 0. RAM contents are not cleared.
- Reset mid-burst: outputs return to reset values on the next edge. A write in that same cycle is suppressed.
- All outputs are registered.
- Classic latency: request sampled at edge k → ack high in cycle k+1+`WAIT_CYCLES`.
- Burst throughput: 1 beat per clock after the first ack.
- `m_wb_dat_i` is 0 whenever ack is low.

## Configuration
- `ETH_WBMEM_RANGE_ERR_EN`
  - Defined: an out-of-range first beat terminates with `m_wb_err_i` instead of `ack`. No write occurs, `m_wb_dat_i`=0, and the FSM returns to IDLE after one cycle, even when `cti`=010.
  - Undefined: the index is taken modulo `DEPTH_WORDS`, the access is acked normally, and `m_wb_err_i` is tied 0.

## Structure
- Package `eth_wbmem_pkg`:
  - CTI constants: `CTI_CLASSIC`, `CTI_INCR`, `CTI_EOB`.
  - BTE constant: `BTE_LINEAR`.
  - State enum `wbmem_state_t` {IDLE, WAIT, ACK}.
- Sub-module `eth_wbmem_ram`: single-port, synchronous-write, 4-lane byte-enabled RAM with an asynchronous read index. The FSM registers the read data.

## Test plan
- Reset, `WAIT_CYCLES`=0: classic write of 32'hDEADBEEF to 0x10 with `sel`=4'hF, then a classic read from 0x10 → ack 1 cycle wide at k+1, read returns 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with `sel`=4'b0101 over 32'hFFFFFFFF → read returns 32'hFF22FF44.
- `WAIT_CYCLES`=3: classic read → ack first high in cycle k+4. Dropping `cyc` at k+2 → no ack, and a subsequent write aborted the same way leaves memory unchanged.
- 4-beat incrementing read from 0x100 (`cti` 010,010,010,111), `WAIT_CYCLES`=0, memory preloaded with words 0x40..0x43 = 1,2,3,4 → ack high 4 consecutive cycles with data 1,2,3,4, then ack low.
- Out-of-range read at `BASE_ADDR`+`DEPTH_WORDS`*4:
  - With the macro defined: err high 1 cycle, ack 0, data 0.
  - With it undefined: ack, with data from word 0.
- Assert `rst` during beat 2 of a write burst → the next cycle has ack=0 and the beat-2 word is unchanged. A new classic cycle afterwards completes normally.
